// File: rtl/pcie_dllp_tx_crc_framer.sv
// Frames 4-byte DLLP bodies into two PHY beats: body, then the 16-bit DLLP CRC.
// Optional counters are enabled with the PCIE_DLLP_TX_STATS_EN macro.
module pcie_dllp_tx_crc_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep_i,
    input  logic                  s_axis_dllp_tvalid_i,
    input  logic                  s_axis_dllp_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_dllp_tuser_i,
    output logic                  s_axis_dllp_tready_o,
    output logic [DATA_WIDTH-1:0] m_axis_phy_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_phy_tkeep_o,
    output logic                  m_axis_phy_tvalid_o,
    output logic                  m_axis_phy_tlast_o,
    output logic [USER_WIDTH-1:0] m_axis_phy_tuser_o,
    input  logic                  m_axis_phy_tready_i,
    output logic                  malformed_o
`ifdef PCIE_DLLP_TX_STATS_EN
    ,
    output logic [15:0]           dllp_count_o,
    output logic [7:0]            malformed_count_o
`endif
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("pcie_dllp_tx_crc_framer supports DATA_WIDTH = 32 only");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BODY = 2'd1;
    localparam logic [1:0] ST_CRC  = 2'd2;

    // LFSR over byte0..byte3 LSB first, then complement and reverse bits per byte.
    function automatic logic [15:0] dllp_crc(input logic [31:0] body);
        logic [15:0] lfsr;
        logic [15:0] inv;
        logic [15:0] res;
        logic        fb;
        lfsr = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb   = lfsr[15] ^ body[i];
            lfsr = {lfsr[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        inv = ~lfsr;
        res = '0;
        for (int b = 0; b < 8; b++) begin
            res[8+b] = inv[15-b];
            res[b]   = inv[7-b];
        end
        return res;
    endfunction

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] body_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [15:0]           crc_q;
    logic                  malformed_q;
    logic                  in_fire;
    logic                  in_good;
    logic                  load;

    assign s_axis_dllp_tready_o = !rst_i &&
                                  ((state == ST_IDLE) || ((state == ST_CRC) && m_axis_phy_tready_i));
    assign in_fire     = s_axis_dllp_tvalid_i && s_axis_dllp_tready_o;
    assign in_good     = (s_axis_dllp_tkeep_i == {KEEP_WIDTH{1'b1}}) && s_axis_dllp_tlast_i;
    assign load        = in_fire && in_good;
    assign malformed_o = malformed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            body_q      <= '0;
            user_q      <= '0;
            crc_q       <= '0;
            malformed_q <= 1'b0;
        end else begin
            malformed_q <= in_fire && !in_good;
            if (load) begin
                body_q <= s_axis_dllp_tdata_i;
                user_q <= s_axis_dllp_tuser_i;
                crc_q  <= dllp_crc(s_axis_dllp_tdata_i);
            end
            case (state)
                ST_IDLE: if (load) state <= ST_BODY;
                ST_BODY: if (m_axis_phy_tready_i) state <= ST_CRC;
                ST_CRC:  if (m_axis_phy_tready_i) state <= load ? ST_BODY : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output beats come straight from registered state, so they hold while stalled.
    always_comb begin
        m_axis_phy_tvalid_o = 1'b0;
        m_axis_phy_tdata_o  = '0;
        m_axis_phy_tkeep_o  = '0;
        m_axis_phy_tlast_o  = 1'b0;
        m_axis_phy_tuser_o  = '0;
        case (state)
            ST_BODY: begin
                m_axis_phy_tvalid_o = 1'b1;
                m_axis_phy_tdata_o  = body_q;
                m_axis_phy_tkeep_o  = 4'hF;
                m_axis_phy_tuser_o  = user_q;
            end
            ST_CRC: begin
                m_axis_phy_tvalid_o = 1'b1;
                m_axis_phy_tdata_o  = {16'h0000, crc_q[7:0], crc_q[15:8]};
                m_axis_phy_tkeep_o  = 4'h3;
                m_axis_phy_tlast_o  = 1'b1;
                m_axis_phy_tuser_o  = user_q;
            end
            default: ;
        endcase
    end

`ifdef PCIE_DLLP_TX_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dllp_count_o      <= '0;
            malformed_count_o <= '0;
        end else begin
            if ((state == ST_CRC) && m_axis_phy_tready_i)
                dllp_count_o <= dllp_count_o + 16'd1;
            if (in_fire && !in_good && (malformed_count_o != 8'hFF))
                malformed_count_o <= malformed_count_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_dllp_tx_crc_framer.sv
// Self-checking bench for pcie_dllp_tx_crc_framer with a polynomial-division CRC model.
// Counter checks run when PCIE_DLLP_TX_STATS_EN is defined.
module tb_pcie_dllp_tx_crc_framer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [2:0]  user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic [2:0]  s_tuser;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic [2:0]  m_tuser;
    logic        m_tready;
    logic        malformed;
`ifdef PCIE_DLLP_TX_STATS_EN
    logic [15:0] dllp_count;
    logic [7:0]  malformed_count;
`endif

    int checks = 0;
    int errors = 0;

    pcie_dllp_tx_crc_framer #(.DATA_WIDTH(32), .USER_WIDTH(3)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .s_axis_dllp_tdata_i  (s_tdata),
        .s_axis_dllp_tkeep_i  (s_tkeep),
        .s_axis_dllp_tvalid_i (s_tvalid),
        .s_axis_dllp_tlast_i  (s_tlast),
        .s_axis_dllp_tuser_i  (s_tuser),
        .s_axis_dllp_tready_o (s_tready),
        .m_axis_phy_tdata_o   (m_tdata),
        .m_axis_phy_tkeep_o   (m_tkeep),
        .m_axis_phy_tvalid_o  (m_tvalid),
        .m_axis_phy_tlast_o   (m_tlast),
        .m_axis_phy_tuser_o   (m_tuser),
        .m_axis_phy_tready_i  (m_tready),
        .malformed_o          (malformed)
`ifdef PCIE_DLLP_TX_STATS_EN
        ,
        .dllp_count_o         (dllp_count),
        .malformed_count_o    (malformed_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // CRC as remainder of (seed*x^32 + M(x)*x^16) mod G, first transmitted bit highest.
    function automatic logic [15:0] model_crc(input logic [31:0] body);
        logic [47:0] d;
        logic [15:0] rem;
        logic [15:0] res;
        d = '0;
        for (int k = 0; k < 32; k++) d[47-k] = body[k];
        d[47:32] = d[47:32] ^ 16'hFFFF;
        for (int j = 47; j >= 16; j--)
            if (d[j]) d[j-:17] = d[j-:17] ^ 17'h1100B;
        rem = ~d[15:0];
        res = '0;
        for (int b = 0; b < 8; b++) begin
            res[15-b] = rem[8+b];
            res[7-b]  = rem[b];
        end
        return res;
    endfunction

    function automatic beat_t body_beat(input logic [31:0] body, input logic [2:0] user);
        return '{data: body, keep: 4'hF, last: 1'b0, user: user};
    endfunction

    function automatic beat_t crc_beat(input logic [31:0] body, input logic [2:0] user);
        logic [15:0] c;
        c = model_crc(body);
        return '{data: {16'h0000, c[7:0], c[15:8]}, keep: 4'h3, last: 1'b1, user: user};
    endfunction

    function automatic beat_t out_beat();
        return beat_t'({m_tdata, m_tkeep, m_tlast, m_tuser});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        s_tuser  = '0;
    endtask

    // Sends one well-formed DLLP from IDLE with tready_i=1 and checks both beats.
    task automatic frame_one(input logic [31:0] body, input logic [2:0] user, input string tag);
        s_tdata  = body;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        s_tuser  = user;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_in_ready: got %b expected 1", tag, s_tready);
        end
        tick();
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || out_beat() !== body_beat(body, user)) begin
            errors++;
            $display("[TB] FAIL %s_beat0: got valid=%b %h expected valid=1 %h",
                     tag, m_tvalid, out_beat(), body_beat(body, user));
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || out_beat() !== crc_beat(body, user)) begin
            errors++;
            $display("[TB] FAIL %s_beat1: got valid=%b %h expected valid=1 %h",
                     tag, m_tvalid, out_beat(), crc_beat(body, user));
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_done: got valid=%b expected 0", tag, m_tvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m_tready = 1'b1;
        tick();
        tick();
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || malformed !== 1'b0 || out_beat() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ready=%b valid=%b mal=%b beat=%h expected 0 0 0 0",
                     s_tready, m_tvalid, malformed, out_beat());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready_after: got %b expected 1", s_tready);
        end
    endtask

    task automatic test_ack();
        frame_one(32'h0000_0000, 3'($urandom_range(0, 7)), "ack");
    endtask

    task automatic test_stall();
        beat_t       got[$];
        beat_t       prev;
        beat_t       cur;
        logic        prev_stall;
        logic [31:0] body;
        logic [2:0]  user;
        body = 32'h0420_1080;
        user = 3'($urandom_range(0, 7));
        s_tdata  = body;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        s_tuser  = user;
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        tick();
        s_tvalid   = 1'b0;
        prev_stall = 1'b0;
        prev       = '0;
        for (int i = 0; i < 16; i++) begin
            m_tready = i[0];
            #1;
            cur = out_beat();
            if (m_tvalid) begin
                if (prev_stall) begin
                    checks++;
                    if (cur !== prev) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got %h expected %h", cur, prev);
                    end
                end
                if (m_tready) got.push_back(cur);
            end
            prev_stall = m_tvalid && !m_tready;
            prev       = cur;
            tick();
        end
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d beats expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== body_beat(body, user) || got[1] !== crc_beat(body, user)) begin
                errors++;
                $display("[TB] FAIL stall_data: got %h %h expected %h %h",
                         got[0], got[1], body_beat(body, user), crc_beat(body, user));
            end
        end
        m_tready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] bodies[4];
        logic [2:0]  users[4];
        beat_t       got[$];
        int          cyc[$];
        int          k;
        for (int i = 0; i < 4; i++) begin
            bodies[i] = $urandom;
            users[i]  = 3'($urandom_range(0, 7));
        end
        k = 0;
        m_tready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_tvalid = (k < 4);
            if (k < 4) begin
                s_tdata = bodies[k];
                s_tuser = users[k];
            end
            #1;
            if (c < 8) begin
                checks++;
                if (s_tready !== ((c % 2) == 0)) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready_c%0d: got %b expected %b", c, s_tready, (c % 2) == 0);
                end
            end
            if (s_tvalid && s_tready) k++;
            if (m_tvalid) begin
                got.push_back(out_beat());
                cyc.push_back(c);
            end
            tick();
        end
        s_tvalid = 1'b0;
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d beats expected 8", got.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (cyc[j] != j + 1) begin
                    errors++;
                    $display("[TB] FAIL b2b_cycle%0d: got cycle %0d expected %0d", j, cyc[j], j + 1);
                end
                checks++;
                if (got[j] !== ((j % 2 == 0) ? body_beat(bodies[j/2], users[j/2])
                                             : crc_beat(bodies[j/2], users[j/2]))) begin
                    errors++;
                    $display("[TB] FAIL b2b_beat%0d: got %h", j, got[j]);
                end
            end
        end
    endtask

    task automatic test_malformed();
        for (int v = 0; v < 2; v++) begin
            s_tdata  = $urandom;
            s_tuser  = 3'($urandom_range(0, 7));
            s_tkeep  = (v == 0) ? 4'h7 : 4'hF;
            s_tlast  = (v == 0) ? 1'b1 : 1'b0;
            s_tvalid = 1'b1;
            m_tready = 1'b1;
            tick();
            idle_inputs();
            checks++;
            if (malformed !== 1'b1 || m_tvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL malformed%0d_pulse: got mal=%b valid=%b expected 1 0", v, malformed, m_tvalid);
            end
            tick();
            checks++;
            if (malformed !== 1'b0 || m_tvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL malformed%0d_after: got mal=%b valid=%b expected 0 0", v, malformed, m_tvalid);
            end
        end
        frame_one($urandom, 3'($urandom_range(0, 7)), "post_malformed");
    endtask

    task automatic test_reset_mid();
        s_tdata  = $urandom;
        s_tuser  = 3'($urandom_range(0, 7));
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        tick();
        s_tvalid = 1'b0;
        tick();
        m_tready = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tlast !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_in_crc: got valid=%b last=%b expected 1 1", m_tvalid, m_tlast);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_ready: got %b expected 0", s_tready);
        end
        tick();
        rst = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_tvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rstmid_no_crc%0d: got valid=%b expected 0", i, m_tvalid);
            end
            tick();
        end
        frame_one($urandom, 3'($urandom_range(0, 7)), "post_reset");
    endtask

    task automatic test_random();
        beat_t exp_q[$];
        beat_t exp;
        int    sent;
        int    cycles;
        logic  exp_mal;
        logic  exp_mal_next;
        logic  accepted;
        sent    = 0;
        exp_mal = 1'b0;
        idle_inputs();
        for (cycles = 0; cycles < 3000; cycles++) begin
            if (sent >= 40 && exp_q.size() == 0 && !s_tvalid) break;
            m_tready = ($urandom_range(0, 3) != 0);
            if (!s_tvalid && sent < 40 && $urandom_range(0, 2) != 0) begin
                s_tdata = $urandom;
                s_tuser = 3'($urandom_range(0, 7));
                s_tkeep = 4'hF;
                s_tlast = 1'b1;
                if ($urandom_range(0, 4) == 0) begin
                    if ($urandom_range(0, 1) == 1) s_tkeep = 4'($urandom_range(0, 14));
                    else s_tlast = 1'b0;
                end
                s_tvalid = 1'b1;
            end
            #1;
            checks++;
            if (malformed !== exp_mal) begin
                errors++;
                $display("[TB] FAIL rand_malformed: got %b expected %b at cycle %0d", malformed, exp_mal, cycles);
            end
            exp_mal_next = 1'b0;
            accepted     = 1'b0;
            if (s_tvalid && s_tready) begin
                accepted = 1'b1;
                sent++;
                if (s_tkeep == 4'hF && s_tlast) begin
                    exp_q.push_back(body_beat(s_tdata, s_tuser));
                    exp_q.push_back(crc_beat(s_tdata, s_tuser));
                end else begin
                    exp_mal_next = 1'b1;
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_unexpected: got %h expected no beat", out_beat());
                end else begin
                    exp = exp_q.pop_front();
                    if (out_beat() !== exp) begin
                        errors++;
                        $display("[TB] FAIL rand_beat: got %h expected %h", out_beat(), exp);
                    end
                end
            end
            tick();
            exp_mal = exp_mal_next;
            if (accepted) s_tvalid = 1'b0;
        end
        checks++;
        if (sent != 40 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_timeout: got sent=%0d pending=%0d expected 40 0", sent, exp_q.size());
        end
        idle_inputs();
        m_tready = 1'b1;
        tick();
    endtask

`ifdef PCIE_DLLP_TX_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) frame_one($urandom, 3'($urandom_range(0, 7)), "stats_good");
        s_tkeep  = 4'h7;
        s_tvalid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (dllp_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL stats_dllp_count: got %0d expected 3", dllp_count);
        end
        checks++;
        if (malformed_count !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL stats_malformed_count: got %h expected ff", malformed_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        idle_inputs();
        test_reset();
        test_ack();
        test_stall();
        test_back_to_back();
        test_malformed();
        test_reset_mid();
        test_random();
`ifdef PCIE_DLLP_TX_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
